// File: rtl/cbus_narb_pkg.sv
// Shared definitions for the N-master cache-bus arbiter: command encodings (common with l2c),
// arbitration mode selectors, FSM state type and a clog2 helper.
package cbus_narb_pkg;

    localparam int unsigned CMD_NO   = 0;
    localparam int unsigned CMD_RD   = 1;
    localparam int unsigned CMD_WR   = 2;
    localparam int unsigned CMD_WRBE = 3;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    // Outstanding-read counter width; MAX_OUT tops out at 15.
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cbus_narb_rr.sv
// Combinational picker: first eligible master at or after the base index, searching with
// wrap-around. In fixed-priority mode the base is forced to 0 so the lowest index wins.
module cbus_narb_rr
    import cbus_narb_pkg::*;
#(
    parameter int unsigned NUM_M = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NUM_M-1:0] elig_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             mode_i,
    output logic [NUM_M-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] cand;

    assign base = mode_i ? ptr_i : '0;

    always_comb begin
        idx_o = '0;
        cand  = '0;
        // Walk offsets from farthest to nearest so the nearest eligible master is kept last.
        for (int k = NUM_M - 1; k >= 0; k--) begin
            cand = IDX_W'((32'(base) + 32'(k)) % NUM_M);
            if (elig_i[cand]) idx_o = cand;
        end
        gnt_o = '0;
        if (|elig_i) gnt_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/cbus_narb.sv
// N-master cache-bus arbiter with registered request issue to the L2 slave, UID-tagged
// response steering and per-master outstanding-read limiting with a sticky error flag.
module cbus_narb
    import cbus_narb_pkg::*;
#(
    parameter int unsigned NUM_M    = 4,
    parameter int unsigned ARB_MODE = 1,
    parameter int unsigned MAX_OUT  = 2,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned CMD_W    = 2,
    parameter int unsigned UID_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_M-1:0]          m_req,
    input  logic [NUM_M*CMD_W-1:0]    m_cmd,
    input  logic [NUM_M*ADDR_W-1:0]   m_addr,
    input  logic [NUM_M*DATA_W/8-1:0] m_data_be,
    input  logic [NUM_M*DATA_W-1:0]   m_data,
    output logic [NUM_M-1:0]          m_ack,
    output logic [NUM_M-1:0]          m_rdy,
    output logic [DATA_W-1:0]         m_rd_data,
    output logic                      s_req,
    output logic [CMD_W-1:0]          s_cmd,
    output logic [ADDR_W-1:0]         s_addr,
    output logic [UID_W-1:0]          s_uid,
    output logic [DATA_W/8-1:0]       s_data_be,
    output logic [DATA_W-1:0]         s_data,
    input  logic                      s_ack,
    input  logic                      s_rdy,
    input  logic [UID_W-1:0]          s_rsp_uid,
    input  logic [DATA_W-1:0]         s_rsp_data,
    output logic                      err
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = (clog2(NUM_M) == 0) ? 1 : clog2(NUM_M);

    state_e             state_q, state_d;
    logic               s_req_q, s_req_d;
    logic [CMD_W-1:0]   s_cmd_q, s_cmd_d;
    logic [ADDR_W-1:0]  s_addr_q, s_addr_d;
    logic [UID_W-1:0]   s_uid_q, s_uid_d;
    logic [BE_W-1:0]    s_be_q, s_be_d;
    logic [DATA_W-1:0]  s_data_q, s_data_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   out_cnt_q [NUM_M];
    logic [CNT_W-1:0]   out_cnt_d [NUM_M];
    logic [NUM_M-1:0]   m_rdy_q, m_rdy_d;
    logic [DATA_W-1:0]  m_rd_data_q, m_rd_data_d;
    logic               err_q, err_d;

    logic [NUM_M-1:0]   elig;
    logic [NUM_M-1:0]   gnt;
    logic [IDX_W-1:0]   pick;
    logic               ack_fire;
    logic               rd_issue;
    logic               uid_ok;
    logic               rsp_ok;
    logic [IDX_W-1:0]   rsp_idx;

    // A master whose read budget is exhausted may still win with a write.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_M; i++) begin
            elig[i] = m_req[i] &&
                      !((m_cmd[i*CMD_W +: CMD_W] == CMD_W'(CMD_RD)) &&
                        (out_cnt_q[i] == CNT_W'(MAX_OUT)));
        end
    end

    cbus_narb_rr #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W)
    ) u_pick (
        .elig_i (elig),
        .ptr_i  (rr_ptr_q),
        .mode_i (ARB_MODE == ARB_RR),
        .gnt_o  (gnt),
        .idx_o  (pick)
    );

    assign ack_fire = (state_q == StBusy) && s_ack;
    assign rd_issue = ack_fire && (s_cmd_q == CMD_W'(CMD_RD));
    assign uid_ok   = 32'(s_rsp_uid) < NUM_M;
    assign rsp_idx  = IDX_W'(s_rsp_uid);
    assign rsp_ok   = s_rdy && uid_ok && (out_cnt_q[rsp_idx] != '0);

    always_comb begin
        m_ack = '0;
        if (ack_fire) m_ack[win_q] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        s_req_d     = s_req_q;
        s_cmd_d     = s_cmd_q;
        s_addr_d    = s_addr_q;
        s_uid_d     = s_uid_q;
        s_be_d      = s_be_q;
        s_data_d    = s_data_q;
        win_d       = win_q;
        rr_ptr_d    = rr_ptr_q;
        m_rdy_d     = '0;
        m_rd_data_d = m_rd_data_q;
        err_d       = err_q;
        for (int i = 0; i < NUM_M; i++) out_cnt_d[i] = out_cnt_q[i];

        unique case (state_q)
            StIdle: begin
                if (|gnt) begin
                    state_d  = StBusy;
                    s_req_d  = 1'b1;
                    win_d    = pick;
                    s_cmd_d  = m_cmd[32'(pick)*CMD_W +: CMD_W];
                    s_addr_d = m_addr[32'(pick)*ADDR_W +: ADDR_W];
                    s_be_d   = m_data_be[32'(pick)*BE_W +: BE_W];
                    s_data_d = m_data[32'(pick)*DATA_W +: DATA_W];
                    s_uid_d  = UID_W'(pick);
                end
            end
            StBusy: begin
                if (s_ack) begin
                    state_d  = StIdle;
                    s_req_d  = 1'b0;
                    rr_ptr_d = (win_q == IDX_W'(NUM_M - 1)) ? '0 : win_q + 1'b1;
                end
            end
        endcase

        // Issue and retire in the same cycle for one master cancel out.
        for (int i = 0; i < NUM_M; i++) begin
            if (rd_issue && (win_q == IDX_W'(i))) out_cnt_d[i] = out_cnt_d[i] + 1'b1;
            if (rsp_ok && (rsp_idx == IDX_W'(i))) out_cnt_d[i] = out_cnt_d[i] - 1'b1;
        end

        if (rsp_ok) begin
            m_rdy_d[rsp_idx] = 1'b1;
            m_rd_data_d      = s_rsp_data;
        end else if (s_rdy) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            s_req_q     <= 1'b0;
            s_cmd_q     <= CMD_W'(CMD_NO);
            s_addr_q    <= '0;
            s_uid_q     <= '0;
            s_be_q      <= '0;
            s_data_q    <= '0;
            win_q       <= '0;
            rr_ptr_q    <= '0;
            m_rdy_q     <= '0;
            m_rd_data_q <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_M; i++) out_cnt_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            s_req_q     <= s_req_d;
            s_cmd_q     <= s_cmd_d;
            s_addr_q    <= s_addr_d;
            s_uid_q     <= s_uid_d;
            s_be_q      <= s_be_d;
            s_data_q    <= s_data_d;
            win_q       <= win_d;
            rr_ptr_q    <= rr_ptr_d;
            m_rdy_q     <= m_rdy_d;
            m_rd_data_q <= m_rd_data_d;
            err_q       <= err_d;
            for (int i = 0; i < NUM_M; i++) out_cnt_q[i] <= out_cnt_d[i];
        end
    end

    assign s_req     = s_req_q;
    assign s_cmd     = s_cmd_q;
    assign s_addr    = s_addr_q;
    assign s_uid     = s_uid_q;
    assign s_data_be = s_be_q;
    assign s_data    = s_data_q;
    assign m_rdy     = m_rdy_q;
    assign m_rd_data = m_rd_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cbus_narb.sv
// Bench for cbus_narb: cycle-by-cycle vector table on a round-robin instance, plus a
// hand-written fixed-priority sequence on a second instance.
module tb_cbus_narb;
    import cbus_narb_pkg::*;

    localparam int unsigned NM = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned CW = 2;
    localparam int unsigned UW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NM-1:0]     m_req;
    logic [NM*CW-1:0]  m_cmd;
    logic [NM*AW-1:0]  m_addr;
    logic [NM*BW-1:0]  m_be;
    logic [NM*DW-1:0]  m_data;
    logic              s_ack, s_rdy, fp_s_ack;
    logic [UW-1:0]     s_rsp_uid;
    logic [DW-1:0]     s_rsp_data;

    logic [NM-1:0] rr_ack, rr_rdy, fp_ack, fp_rdy;
    logic [DW-1:0] rr_rdata, fp_rdata, rr_sdata, fp_sdata;
    logic          rr_sreq, fp_sreq, rr_err, fp_err;
    logic [CW-1:0] rr_scmd, fp_scmd;
    logic [AW-1:0] rr_saddr, fp_saddr;
    logic [UW-1:0] rr_suid, fp_suid;
    logic [BW-1:0] rr_sbe, fp_sbe;

    function automatic logic [AW-1:0] addr_of(input int i);
        return AW'(32'h1000 + 32'h0111 * i);
    endfunction
    function automatic logic [DW-1:0] data_of(input int i);
        return DW'(32'hDA00_0000 + 32'h0001_0101 * i);
    endfunction
    function automatic logic [BW-1:0] be_of(input int i);
        return BW'(1 << i);
    endfunction
    function automatic logic [DW-1:0] rdata_of(input logic [UW-1:0] u);
        return 32'hBEEF_0000 | 32'(u);
    endfunction
    function automatic logic [CW-1:0] cmd_of(input logic [NM*CW-1:0] c, input int i);
        return c[i*CW +: CW];
    endfunction

    assign s_rsp_data = rdata_of(s_rsp_uid);

    cbus_narb #(
        .NUM_M(NM), .ARB_MODE(1), .MAX_OUT(2), .ADDR_W(AW), .DATA_W(DW), .CMD_W(CW), .UID_W(UW)
    ) u_rr (
        .clk(clk), .rst(rst), .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr),
        .m_data_be(m_be), .m_data(m_data), .m_ack(rr_ack), .m_rdy(rr_rdy),
        .m_rd_data(rr_rdata), .s_req(rr_sreq), .s_cmd(rr_scmd), .s_addr(rr_saddr),
        .s_uid(rr_suid), .s_data_be(rr_sbe), .s_data(rr_sdata), .s_ack(s_ack),
        .s_rdy(s_rdy), .s_rsp_uid(s_rsp_uid), .s_rsp_data(s_rsp_data), .err(rr_err)
    );

    cbus_narb #(
        .NUM_M(NM), .ARB_MODE(0), .MAX_OUT(2), .ADDR_W(AW), .DATA_W(DW), .CMD_W(CW), .UID_W(UW)
    ) u_fp (
        .clk(clk), .rst(rst), .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr),
        .m_data_be(m_be), .m_data(m_data), .m_ack(fp_ack), .m_rdy(fp_rdy),
        .m_rd_data(fp_rdata), .s_req(fp_sreq), .s_cmd(fp_scmd), .s_addr(fp_saddr),
        .s_uid(fp_suid), .s_data_be(fp_sbe), .s_data(fp_sdata), .s_ack(fp_s_ack),
        .s_rdy(1'b0), .s_rsp_uid(UW'(0)), .s_rsp_data(s_rsp_data), .err(fp_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        logic          rst;
        logic [3:0]    req;
        logic [7:0]    cmd;
        logic          ack;
        logic          rdy;
        logic [3:0]    uid;
        logic          e_sreq;
        logic [3:0]    e_suid;
        logic [3:0]    e_ack;
        logic [3:0]    e_rdy;
        logic          e_err;
    } vec_t;

    function automatic vec_t mk(input int r, input int q, input int c, input int a, input int d,
                                input int u, input int es, input int eu, input int ea,
                                input int ed, input int ee);
        vec_t v;
        v.rst = r[0];      v.req = 4'(q);     v.cmd = 8'(c);     v.ack = a[0];
        v.rdy = d[0];      v.uid = 4'(u);     v.e_sreq = es[0];  v.e_suid = 4'(eu);
        v.e_ack = 4'(ea);  v.e_rdy = 4'(ed);  v.e_err = ee[0];
        return v;
    endfunction

    vec_t tv[$];

    initial begin
        logic [UW-1:0] prev_uid;
        logic          prev_rst;
        int            su;

        for (int i = 0; i < NM; i++) begin
            m_addr[i*AW +: AW] = addr_of(i);
            m_data[i*DW +: DW] = data_of(i);
            m_be[i*BW +: BW]   = be_of(i);
        end
        rst = 1'b1; m_req = 4'hF; m_cmd = 8'hAA;
        s_ack = 1'b0; s_rdy = 1'b0; s_rsp_uid = '0; fp_s_ack = 1'b0;

        // rst req  cmd    ack rdy uid | sreq suid ack rdy err
        tv.push_back(mk(1, 'hF, 'hAA, 0, 0, 0,  0, 0, 'h0, 'h0, 0));
        tv.push_back(mk(0, 'hF, 'hAA, 0, 0, 0,  0, 0, 'h0, 'h0, 0));
        tv.push_back(mk(0, 'hF, 'hAA, 1, 0, 0,  1, 0, 'h1, 'h0, 0));
        tv.push_back(mk(0, 'hF, 'hAA, 1, 0, 0,  0, 0, 'h0, 'h0, 0));
        tv.push_back(mk(0, 'hF, 'hAA, 1, 0, 0,  1, 1, 'h2, 'h0, 0));
        tv.push_back(mk(0, 'hF, 'hAA, 0, 0, 0,  0, 0, 'h0, 'h0, 0));
        tv.push_back(mk(0, 'hF, 'hAA, 1, 0, 0,  1, 2, 'h4, 'h0, 0));
        tv.push_back(mk(0, 'hF, 'hAA, 0, 0, 0,  0, 0, 'h0, 'h0, 0));
        tv.push_back(mk(0, 'hF, 'hAA, 0, 0, 0,  1, 3, 'h0, 'h0, 0));
        tv.push_back(mk(0, 'hF, 'hAA, 1, 0, 0,  1, 3, 'h8, 'h0, 0));
        tv.push_back(mk(0, 'hF, 'hAA, 0, 0, 0,  0, 0, 'h0, 'h0, 0));
        tv.push_back(mk(0, 'hF, 'hAA, 1, 0, 0,  1, 0, 'h1, 'h0, 0));
        // master 2 reads up to its limit; master 0 write slips past the blocked read
        tv.push_back(mk(0, 'h4, 'h12, 0, 0, 0,  0, 0, 'h0, 'h0, 0));
        tv.push_back(mk(0, 'h4, 'h12, 1, 0, 0,  1, 2, 'h4, 'h0, 0));
        tv.push_back(mk(0, 'h4, 'h12, 0, 0, 0,  0, 0, 'h0, 'h0, 0));
        tv.push_back(mk(0, 'h4, 'h12, 1, 0, 0,  1, 2, 'h4, 'h0, 0));
        tv.push_back(mk(0, 'h4, 'h12, 0, 0, 0,  0, 0, 'h0, 'h0, 0));
        tv.push_back(mk(0, 'h4, 'h12, 0, 0, 0,  0, 0, 'h0, 'h0, 0));
        tv.push_back(mk(0, 'h5, 'h12, 0, 0, 0,  0, 0, 'h0, 'h0, 0));
        tv.push_back(mk(0, 'h5, 'h12, 1, 0, 0,  1, 0, 'h1, 'h0, 0));
        tv.push_back(mk(0, 'h4, 'h12, 0, 1, 2,  0, 0, 'h0, 'h0, 0));
        tv.push_back(mk(0, 'h4, 'h12, 0, 0, 0,  0, 0, 'h0, 'h4, 0));
        tv.push_back(mk(0, 'h4, 'h12, 1, 0, 0,  1, 2, 'h4, 'h0, 0));
        // master 1: ack and response together leave its count at 1
        tv.push_back(mk(0, 'h2, 'h16, 0, 0, 0,  0, 0, 'h0, 'h0, 0));
        tv.push_back(mk(0, 'h2, 'h16, 1, 0, 0,  1, 1, 'h2, 'h0, 0));
        tv.push_back(mk(0, 'h2, 'h16, 0, 0, 0,  0, 0, 'h0, 'h0, 0));
        tv.push_back(mk(0, 'h2, 'h16, 1, 1, 1,  1, 1, 'h2, 'h0, 0));
        tv.push_back(mk(0, 'h2, 'h16, 0, 0, 0,  0, 0, 'h0, 'h2, 0));
        tv.push_back(mk(0, 'h2, 'h16, 1, 0, 0,  1, 1, 'h2, 'h0, 0));
        tv.push_back(mk(0, 'h2, 'h16, 0, 0, 0,  0, 0, 'h0, 'h0, 0));
        tv.push_back(mk(0, 'h2, 'h16, 0, 0, 0,  0, 0, 'h0, 'h0, 0));
        // error cases: zero outstanding, then out-of-range uid; reset clears err
        tv.push_back(mk(0, 'h0, 'h16, 0, 1, 3,  0, 0, 'h0, 'h0, 0));
        tv.push_back(mk(0, 'h0, 'h16, 0, 0, 0,  0, 0, 'h0, 'h0, 1));
        tv.push_back(mk(1, 'h0, 'h16, 0, 0, 0,  0, 0, 'h0, 'h0, 1));
        tv.push_back(mk(0, 'h0, 'h16, 0, 1, 5,  0, 0, 'h0, 'h0, 0));
        tv.push_back(mk(0, 'h0, 'h16, 0, 0, 0,  0, 0, 'h0, 'h0, 1));
        tv.push_back(mk(1, 'h0, 'h16, 0, 0, 0,  0, 0, 'h0, 'h0, 1));
        tv.push_back(mk(0, 'h0, 'h16, 0, 0, 0,  0, 0, 'h0, 'h0, 0));

        repeat (2) @(posedge clk);
        prev_uid = '0;
        prev_rst = 1'b1;
        for (int n = 0; n < tv.size(); n++) begin
            @(negedge clk);
            rst = tv[n].rst; m_req = tv[n].req; m_cmd = tv[n].cmd;
            s_ack = tv[n].ack; s_rdy = tv[n].rdy; s_rsp_uid = tv[n].uid;
            #1;
            su = int'(tv[n].e_suid);
            chk($sformatf("v%0d s_req", n), 64'(rr_sreq), 64'(tv[n].e_sreq));
            chk($sformatf("v%0d m_ack", n), 64'(rr_ack), 64'(tv[n].e_ack));
            chk($sformatf("v%0d m_rdy", n), 64'(rr_rdy), 64'(tv[n].e_rdy));
            chk($sformatf("v%0d err", n), 64'(rr_err), 64'(tv[n].e_err));
            if (tv[n].e_sreq) begin
                chk($sformatf("v%0d s_uid", n), 64'(rr_suid), 64'(tv[n].e_suid));
                chk($sformatf("v%0d s_fields", n), 64'({rr_scmd, rr_saddr, rr_sbe, rr_sdata}),
                    64'({cmd_of(tv[n].cmd, su), addr_of(su), be_of(su), data_of(su)}));
            end
            if (tv[n].e_rdy != 4'h0)
                chk($sformatf("v%0d m_rd_data", n), 64'(rr_rdata), 64'(rdata_of(prev_uid)));
            if (prev_rst && !tv[n].rst)
                chk($sformatf("v%0d reset_regs", n),
                    64'({rr_scmd, rr_saddr, rr_suid, rr_sbe, rr_sdata}), 64'(0));
            if (prev_rst && !tv[n].rst)
                chk($sformatf("v%0d reset_rd_data", n), 64'(rr_rdata), 64'(0));
            prev_uid = tv[n].uid;
            prev_rst = tv[n].rst;
        end

        // Fixed priority: master 1 keeps winning over master 3 until it stops requesting.
        @(negedge clk);
        rst = 1'b1; m_req = 4'h0; m_cmd = 8'hAA; s_ack = 1'b0; s_rdy = 1'b0; fp_s_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0; m_req = 4'b1010;
        #1 chk("fp idle s_req", 64'(fp_sreq), 64'(0));
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            fp_s_ack = 1'b1;
            #1;
            chk($sformatf("fp g%0d s_req", g), 64'(fp_sreq), 64'(1));
            chk($sformatf("fp g%0d s_uid", g), 64'(fp_suid), 64'(1));
            chk($sformatf("fp g%0d m_ack", g), 64'(fp_ack), 64'(4'b0010));
            @(negedge clk);
            fp_s_ack = 1'b0;
            if (g == 2) m_req = 4'b1000;
            #1;
            chk($sformatf("fp g%0d idle s_req", g), 64'(fp_sreq), 64'(0));
            chk($sformatf("fp g%0d idle m_ack", g), 64'(fp_ack), 64'(0));
        end
        @(negedge clk);
        fp_s_ack = 1'b1;
        #1;
        chk("fp m3 s_uid", 64'(fp_suid), 64'(3));
        chk("fp m3 m_ack", 64'(fp_ack), 64'(4'b1000));
        chk("fp m3 s_fields", 64'({fp_scmd, fp_saddr, fp_sbe, fp_sdata}),
            64'({cmd_of(m_cmd, 3), addr_of(3), be_of(3), data_of(3)}));
        @(negedge clk);
        fp_s_ack = 1'b0; m_req = 4'h0;
        #1;
        chk("fp m_rdy", 64'(fp_rdy), 64'(0));
        chk("fp err", 64'(fp_err), 64'(0));
        chk("fp m_rd_data", 64'(fp_rdata), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
